// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to req0.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_ctrl,
    input  logic        req0_setflags,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_ctrl,
    input  logic        req1_setflags,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    output logic [3:0]  rsp0_flags,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic [3:0]  rsp1_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_idle;
    logic        w_grant1;
    logic        w_accept;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_ctrl;
    logic        r_id;
    logic        r_setflags;
    logic [31:0] r_result;
    logic [3:0]  r_rsp_flags;
    logic [3:0]  r_flags;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic r_last;

    // On contention, req1 wins only if req0 took the previous grant.
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant1;
        end
    end
`else
    assign w_grant1 = req1_valid & ~req0_valid;
`endif

    // reset_n gates the readies so none is visible while reset is held.
    assign w_idle     = (r_state == S_IDLE) & reset_n;
    assign req0_ready = w_idle & req0_valid & ~w_grant1;
    assign req1_ready = w_idle & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= '0;
            r_id        <= 1'b0;
            r_setflags  <= 1'b0;
            r_result    <= '0;
            r_rsp_flags <= '0;
            r_flags     <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= w_grant1 ? req1_a        : req0_a;
                r_alu_b    <= w_grant1 ? req1_b        : req0_b;
                r_alu_ctrl <= w_grant1 ? req1_ctrl     : req0_ctrl;
                r_setflags <= w_grant1 ? req1_setflags : req0_setflags;
                r_id       <= w_grant1;
            end
            if (r_state == S_EXEC) begin
                r_result    <= alu_result;
                r_rsp_flags <= alu_flags;
                if (r_setflags) begin
                    r_flags <= alu_flags;
                end
            end
        end
    end

    assign rsp0_valid  = (r_state == S_RESP) & ~r_id;
    assign rsp1_valid  = (r_state == S_RESP) & r_id;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_flags  = r_rsp_flags;
    assign rsp1_flags  = r_rsp_flags;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign flags_q     = r_flags;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU; honours ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_setflags;
    logic        req1_valid, req1_ready, req1_setflags;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic [3:0]  alu_flags, flags_q;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_setflags(req1_setflags),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU: 000 add, 001 sub (C = no borrow), 010 and, 011 or, 100 xor, others 0.
    always_comb begin
        logic [32:0] s;
        logic        c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        alu_result = '0;
        case (alu_ctrl)
            3'b000: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = s[31:0];
                c = s[32];
                v = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b001: begin
                alu_result = alu_a - alu_b;
                c = (alu_a >= alu_b);
                v = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_flags = {alu_result[31], (alu_result == 32'd0), c, v};
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic        sf;
        logic [31:0] exp_res;
        logic [3:0]  exp_fl;
        logic [3:0]  exp_fq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input logic sf);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_setflags = sf;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_setflags = sf;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle N+3.
    task automatic run_op(input vec_t t, input string tag);
        int unsigned w;
        logic        rdy;
        drive(t.id, 1'b1, t.a, t.b, t.ctrl, t.sf);
        #1;
        w = 0;
        rdy = t.id ? req1_ready : req0_ready;
        while (!rdy && w < 8) begin
            @(negedge clk); #1;
            w++;
            rdy = t.id ? req1_ready : req0_ready;
        end
        chk({tag, "_accept_latency"}, w, 0);
        if (!rdy) begin
            drive(t.id, 1'b0, t.a, t.b, t.ctrl, t.sf);
            return;
        end
        @(posedge clk); #1;
        drive(t.id, 1'b0, t.a, t.b, t.ctrl, t.sf);
        @(negedge clk);
        chk({tag, "_exec_busy"}, busy, 1);
        chk({tag, "_exec_alu_a"}, alu_a, t.a);
        chk({tag, "_exec_alu_b"}, alu_b, t.b);
        chk({tag, "_exec_alu_ctrl"}, alu_ctrl, t.ctrl);
        chk({tag, "_exec_rsp_quiet"}, {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk);
        chk({tag, "_resp_strobe"}, {rsp1_valid, rsp0_valid}, t.id ? 2 : 1);
        chk({tag, "_resp_result"}, t.id ? rsp1_result : rsp0_result, t.exp_res);
        chk({tag, "_resp_flags"}, t.id ? rsp1_flags : rsp0_flags, t.exp_fl);
        chk({tag, "_flags_q"}, flags_q, t.exp_fq);
        @(negedge clk);
        chk({tag, "_idle_strobe_off"}, {rsp1_valid, rsp0_valid, busy}, 0);
        chk({tag, "_result_held"}, t.id ? rsp1_result : rsp0_result, t.exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        t;
        int unsigned w;
        logic        grants[4];
        logic        exp_g[4];
        int unsigned ng;

        vecs[0] = '{1'b0, 32'd5,        32'd3,        3'b000, 1'b1, 32'h00000008, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 32'd3,        32'd3,        3'b001, 1'b1, 32'h00000000, 4'b0110, 4'b0110};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'd1,        3'b000, 1'b0, 32'h80000000, 4'b1001, 4'b0110};
        vecs[3] = '{1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b010, 1'b0, 32'h0000F000, 4'b0000, 4'b0110};
        vecs[4] = '{1'b0, 32'd1,        32'd2,        3'b001, 1'b1, 32'hFFFFFFFF, 4'b1000, 4'b1000};
        vecs[5] = '{1'b1, 32'd123,      32'd4,        3'b101, 1'b1, 32'h00000000, 4'b0100, 4'b0100};
        vecs[6] = '{1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 3'b100, 1'b0, 32'hF0F00F0F, 4'b1000, 4'b0100};
        vecs[7] = '{1'b1, 32'h80000000, 32'h00000001, 3'b011, 1'b1, 32'h80000001, 4'b1000, 4'b1000};

`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        reset_n = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_rsp_result", rsp0_result, 0);
        req0_valid = 1'b1;
        #1 chk("rst_ready_gated", {req1_ready, req0_ready}, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed while an op is in EXEC: op must vanish without a trace.
        do_reset();
        drive(1'b0, 1'b1, 32'd1, 32'd2, 3'b001, 1'b1);
        #1 chk("midrst_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_exec", busy, 1);
        #1 reset_n = 1'b0;
        #1 chk("midrst_busy_low", busy, 0);
        chk("midrst_alu_a_clr", alu_a, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_strobe%0d", i), {rsp1_valid, rsp0_valid}, 0);
            chk($sformatf("midrst_flags_q%0d", i), flags_q, 0);
            chk($sformatf("midrst_idle%0d", i), busy, 0);
        end
        run_op(vecs[0], "postrst");

        // req1 payload changes while it waits behind req0.
        do_reset();
        drive(1'b0, 1'b1, 32'd1, 32'd1, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 32'd10, 32'd20, 3'b000, 1'b0);
        #1 chk("pay_first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        req1_a = 32'd100;
        #1 chk("pay_ready_low_exec", req1_ready, 0);
        @(negedge clk);
        chk("pay_rsp0_strobe", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("pay_rsp0_result", rsp0_result, 32'd2);
        w = 0;
        #1;
        while (!req1_ready && w < 8) begin
            @(negedge clk); #1;
            w++;
        end
        chk("pay_req1_wait", w, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("pay_alu_a_new", alu_a, 32'd100);
        @(negedge clk);
        chk("pay_rsp1_strobe", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("pay_rsp1_result", rsp1_result, 32'd120);

        // Both requesters valid continuously.
        do_reset();
        drive(1'b0, 1'b1, 32'd7, 32'd1, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 32'd9, 32'd1, 3'b000, 1'b0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (busy) begin
                chk($sformatf("arb_ready_low_c%0d", c), {req1_ready, req0_ready}, 0);
            end else begin
                chk($sformatf("arb_one_ready_c%0d", c), req1_ready ^ req0_ready, 1);
                grants[ng] = req1_ready;
                ng++;
            end
            @(negedge clk);
        end
        chk("arb_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
